// File: rtl/mips_mem_initiator.sv
// mips_mem_initiator: load/store initiator between the MIPS datapath and a
// 32-bit byte-lane memory bus. Each CPU op becomes at most one word-aligned
// bus transaction; misaligned accesses and illegal ops complete with an error
// and never touch the bus.
// Optional build macro MEM_TIMEOUT_EN: abort a bus cycle that has been
// stalled by mem_waitrequest for TIMEOUT_CYCLES cycles.
module mips_mem_initiator #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_rt_old,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic [31:0]       mem_writedata,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] CAPT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;

   logic [1:0]  state;
   logic [3:0]  op_q;      // captured op, needed again in CAPT
   logic [1:0]  off_q;     // captured byte offset within the word
   logic [31:0] rt_old_q;  // merge source for LWL/LWR

   // Legal op with an offset the access size allows.
   function automatic logic access_ok(input logic [3:0] op, input logic [1:0] o);
      // NOTE: every function/always_comb output gets a default first so no
      // path can leave it unassigned (that is what infers a latch).
      access_ok = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: access_ok = 1'b1;
         OP_LH, OP_LHU, OP_SH:                 access_ok = ~o[0];
         OP_LW, OP_SW:                         access_ok = (o == 2'd0);
         default:                              access_ok = 1'b0;
      endcase
   endfunction

   // Little-endian lane enables for the access.
   function automatic logic [3:0] lane_enables(input logic [3:0] op, input logic [1:0] o);
      lane_enables = 4'b0000;
      case (op)
         OP_LB, OP_LBU, OP_SB: lane_enables = 4'b0001 << o;
         OP_LH, OP_LHU, OP_SH: lane_enables = o[1] ? 4'b1100 : 4'b0011;
         OP_LW, OP_SW:         lane_enables = 4'b1111;
         OP_LWL:               lane_enables = (4'b0010 << o) - 4'd1;  // lanes 0..o
         OP_LWR:               lane_enables = 4'b1111 << o;           // lanes o..3
         default:              lane_enables = 4'b0000;
      endcase
   endfunction

   // Store data replicated across the word so the enabled lanes carry it
   // whatever the offset.
   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] w);
      store_data = 32'h0;
      case (op)
         OP_SB:   store_data = {4{w[7:0]}};
         OP_SH:   store_data = {2{w[15:0]}};
         OP_SW:   store_data = w;
         default: store_data = 32'h0;
      endcase
   endfunction

   // Register result from the returned word: extend, or merge for LWL/LWR.
   function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] o,
                                               input logic [31:0] rd, input logic [31:0] rt);
      logic [4:0]  sh_lo;
      logic [4:0]  sh_hi;
      logic [31:0] d;
      sh_lo = {o, 3'b000};   // 8*o
      sh_hi = {~o, 3'b000};  // 8*(3-o)
      d     = rd >> sh_lo;
      load_result = 32'h0;
      case (op)
         OP_LB:   load_result = {{24{d[7]}}, d[7:0]};
         OP_LBU:  load_result = {24'h0, d[7:0]};
         OP_LH:   load_result = {{16{d[15]}}, d[15:0]};
         OP_LHU:  load_result = {16'h0, d[15:0]};
         OP_LW:   load_result = rd;
         OP_LWL:  load_result = (rd << sh_hi) | (rt & ((32'h1 << sh_hi) - 32'h1));
         OP_LWR:  load_result = d | (rt & ~(32'hFFFF_FFFF >> sh_lo));
         default: load_result = 32'h0;
      endcase
   endfunction

   assign req_ready = (state == IDLE);

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_cnt;
   logic          timeout_hit;

   assign timeout_hit = (state == BUS) && mem_waitrequest &&
                        (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Count consecutive stalled BUS cycles; cleared on any other cycle or abort.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if ((state == BUS) && mem_waitrequest && !timeout_hit) begin
         wait_cnt <= wait_cnt + TW'(1);
      end else begin
         wait_cnt <= '0;
      end
   end
`endif

   // Request FSM: accept, drive one registered bus cycle, capture, respond.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every register
      // in this block sees the pre-edge value of the others.
      if (!reset_n) begin
         state          <= IDLE;
         op_q           <= 4'd0;
         off_q          <= 2'd0;
         rt_old_q       <= 32'h0;
         resp_valid     <= 1'b0;
         resp_error     <= 1'b0;
         resp_rdata     <= 32'h0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= 4'b0000;
         mem_writedata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q     <= req_op;
                  off_q    <= req_addr[1:0];
                  rt_old_q <= req_rt_old;
                  if (!access_ok(req_op, req_addr[1:0])) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                  end else begin
                     // The bus registers double as the captured address and
                     // store data; they stay put until the slave accepts.
                     state          <= BUS;
                     mem_read       <= ~req_op[3];
                     mem_write      <= req_op[3];
                     mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_byteenable <= lane_enables(req_op, req_addr[1:0]);
                     mem_writedata  <= store_data(req_op, req_wdata);
                  end
               end
            end
            BUS: begin
               if (!mem_waitrequest) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (op_q[3]) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= CAPT;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (timeout_hit) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_error <= 1'b1;
               end
`endif
            end
            CAPT: begin
               // Read data is valid in the cycle after acceptance.
               resp_rdata <= load_result(op_q, off_q, mem_readdata, rt_old_q);
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               resp_valid <= 1'b0;
               resp_error <= 1'b0;
               resp_rdata <= 32'h0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mips_mem_initiator.md
Name: mips_mem_initiator

Overview:
- Load/store initiator between the MIPS datapath and the byte-lane memory (32-bit word bus, 4-bit byteenable, registered read data one cycle after the address is accepted).
- Converts a CPU memory op (LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW) into one word-aligned bus transaction with correct byteenable and lane-shifted write data.
- Extends or merges returned lanes into the register result.
- Detects misaligned accesses and never issues bus cycles for them.

Parameters:
- ADDR_W, 32, width of CPU and bus addresses.
- TIMEOUT_CYCLES, 255, waitrequest cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  block can accept a request.
- req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; other codes are illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rt).
- req_rt_old  in  32  current rt value, merge source for LWL/LWR.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned access, illegal op or timeout; valid with resp_valid.
- mem_address  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  4  lane enables; bit i selects bits 8i+7:8i.
- mem_writedata  out  32  lane-shifted store data.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  32  valid the cycle after the read is accepted.

Behaviour:
- Reset (asynchronous, any state): state IDLE. req_ready=1. resp_valid=0, resp_error=0, resp_rdata=0. mem_read=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0. Any in-flight transaction is dropped.
- State IDLE: req_ready=1. On req_valid, capture op/addr/wdata/rt_old. Let o = addr[1:0].
  - Misaligned (half with o[0]=1, word with o≠0) or illegal op: go to DONE with error=1; no bus strobe.
  - Otherwise go to BUS.
- State BUS: bus outputs are registered and held stable while mem_waitrequest=1.
  - Store: go to DONE on the first cycle with mem_waitrequest=0.
  - Load: go to CAPT on the first cycle with mem_waitrequest=0.
- State CAPT: latch mem_readdata; compute result; go to DONE.
- State DONE: resp_valid=1 for exactly one cycle; all bus strobes 0; return to IDLE. req_ready=0 in every state except IDLE.
- Latency from the accept edge (zero wait states):
  - Error: resp_valid next cycle.
  - Store: 2 cycles.
  - Load: 3 cycles.
  - Each waitrequest cycle adds 1.
- Byte enables (little-endian lanes):
  - SB/LB/LBU: 1<<o.
  - SH/LH/LHU: 0011 if o=0, 1100 if o=2.
  - SW/LW: 1111.
  - LWL: lanes 0..o.
  - LWR: lanes o..3.
- Write data: wdata shifted left by 8·o, with byte and half values replicated into the selected lanes.
- Load result, with d = readdata >> 8·o:
  - LB/LH: sign-extended. LBU/LHU: zero-extended. LW: readdata.
  - LWL: (readdata << 8·(3−o)) | (rt_old & ((1<<8·(3−o))−1)).
  - LWR: (readdata >> 8·o) | (rt_old & ~(32'hFFFFFFFF >> 8·o)).
- req_valid outside IDLE is ignored. Inputs are sampled only on the accept edge.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
  - Defined: a counter runs in BUS while mem_waitrequest=1. When it reaches TIMEOUT_CYCLES, strobes drop, the block goes to DONE with resp_error=1 and resp_rdata=0, and the counter clears.
  - Undefined: BUS waits indefinitely; no counter logic is present.

Test Plan:
- LW at 0x00000010, readdata 0xDEADBEEF, no wait: byteenable 1111, address 0x10; resp_valid 3 cycles after accept with rdata 0xDEADBEEF, error 0.
- LB at 0x13 with readdata 0x80112233: byteenable 1000, rdata 0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at 0x22 with wdata 0x0000ABCD, waitrequest held 2 cycles: address 0x20, byteenable 1100, writedata 0xABCDxxxx with the upper half 0xABCD held stable for all 3 cycles; resp_valid 4 cycles after accept.
- LWL at 0x41 with rt_old 0x11223344 and readdata 0xAABBCCDD: byteenable 0011, rdata 0xCCDD3344. LWR at 0x41, same inputs: byteenable 1110, rdata 0x11AABBCC.
- LH at 0x03, then op 7: each gives resp_error=1 next cycle, no mem_read/mem_write pulse, rdata 0.
- Reset_n pulled low mid-BUS: outputs zero immediately (asynchronously). After release, req_ready=1 and a new LW completes normally. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest stuck high gives resp_error=1 after 4 stall cycles.
